alu_arbiter: RTL and testbench

- Shares one ALU instance between two requesters (req0, req1) using round-robin arbitration and a valid/ready handshake on both the request and response sides.
- Registers the winning operands, drives the shared ALU for one cycle, captures s/z, and holds the response until the owning requester accepts it.
- Sits between the CPU execute stage (req0) and a co-processor/DMA checksum unit (req1) and the single ALU datapath.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_rr_pick.sv | 19 +
 rtl/alu_arbiter.sv | 161 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALU op codes, FSM states, defaults.
// The optional ALU_ARB_HAMM32_EN build uses HAMM_LANES / HAMM_LANE_W for multi-pass Hamming.
package alu_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;

  localparam logic [3:0] ALUC_ADD  = 4'b0000;
  localparam logic [3:0] ALUC_SUB  = 4'b0100;
  localparam logic [3:0] ALUC_AND  = 4'b0001;
  localparam logic [3:0] ALUC_OR   = 4'b0101;
  localparam logic [3:0] ALUC_XOR  = 4'b0010;
  localparam logic [3:0] ALUC_LUI  = 4'b0110;
  localparam logic [3:0] ALUC_SLL  = 4'b0011;
  localparam logic [3:0] ALUC_SRL  = 4'b0111;
  localparam logic [3:0] ALUC_SRA  = 4'b1111;
  localparam logic [3:0] ALUC_HAMM = 4'b1011;

  // The ALU counts differing bits of one 4-bit lane per pass.
  localparam int unsigned HAMM_LANES  = 8;
  localparam int unsigned HAMM_LANE_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } arb_state_e;

  function automatic logic is_hamm(input logic [3:0] aluc);
    return aluc == ALUC_HAMM;
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational 2-way round-robin picker: a lone requester wins, a tie goes to the
// requester that did not win last time.
module alu_rr_pick (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters with round-robin arbitration.
// Define ALU_ARB_HAMM32_EN to run HAMM as an 8-pass full-width Hamming distance.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned RST_PRIO = 0
) (
  input  logic              clock,
  input  logic              resetn,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [3:0]        req0_aluc,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_s,
  output logic              rsp0_z,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [3:0]        req1_aluc,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_s,
  output logic              rsp1_z,

  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_aluc,
  input  logic [DATA_W-1:0] alu_s,
  input  logic              alu_z
);

  // last_grant resets to the other requester so RST_PRIO wins the first tie.
  localparam logic LastGrantRst = (RST_PRIO == 0) ? 1'b1 : 1'b0;

  arb_state_e        state_q;
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;
  logic [3:0]        op_aluc_q;
  logic              owner_q;
  logic              last_grant_q;

  logic [1:0]        grant;
  logic              exec_done;
  logic [DATA_W-1:0] exec_s;
  logic              exec_z;
  logic              rsp_accept;

  alu_rr_pick u_pick (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign req0_ready = (state_q == StIdle) & grant[0];
  assign req1_ready = (state_q == StIdle) & grant[1];
  assign alu_aluc   = op_aluc_q;
  assign rsp_accept = owner_q ? rsp1_ready : rsp0_ready;

`ifdef ALU_ARB_HAMM32_EN
  logic [2:0] k_q;
  logic [5:0] sum_q;
  logic [5:0] hamm_total;
  logic       hamm_op;

  assign hamm_op    = is_hamm(op_aluc_q);
  assign hamm_total = sum_q + alu_s[5:0];
  assign alu_a      = hamm_op ? (op_a_q >> {k_q, 2'b00}) : op_a_q;
  assign alu_b      = hamm_op ? (op_b_q >> {k_q, 2'b00}) : op_b_q;

  always_comb begin
    exec_done = 1'b1;
    exec_s    = alu_s;
    exec_z    = alu_z;
    if (hamm_op) begin
      exec_done = (k_q == 3'(HAMM_LANES - 1));
      exec_s    = DATA_W'(hamm_total);
      exec_z    = (hamm_total == 6'd0);
    end
  end
`else
  assign alu_a     = op_a_q;
  assign alu_b     = op_b_q;
  assign exec_done = 1'b1;
  assign exec_s    = alu_s;
  assign exec_z    = alu_z;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_aluc_q    <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= LastGrantRst;
      rsp0_valid   <= 1'b0;
      rsp0_s       <= '0;
      rsp0_z       <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp1_s       <= '0;
      rsp1_z       <= 1'b0;
`ifdef ALU_ARB_HAMM32_EN
      k_q          <= '0;
      sum_q        <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|grant) begin
            owner_q      <= grant[1];
            last_grant_q <= grant[1];
            op_a_q       <= grant[1] ? req1_a    : req0_a;
            op_b_q       <= grant[1] ? req1_b    : req0_b;
            op_aluc_q    <= grant[1] ? req1_aluc : req0_aluc;
            state_q      <= StExec;
          end
        end
        StExec: begin
`ifdef ALU_ARB_HAMM32_EN
          if (!exec_done) begin
            k_q   <= k_q + 3'd1;
            sum_q <= hamm_total;
          end else begin
            k_q   <= '0;
            sum_q <= '0;
          end
`endif
          if (exec_done) begin
            if (owner_q) begin
              rsp1_valid <= 1'b1;
              rsp1_s     <= exec_s;
              rsp1_z     <= exec_z;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_s     <= exec_s;
              rsp0_z     <= exec_z;
            end
            state_q <= StResp;
          end
        end
        StResp: begin
          // Accept returns to IDLE only; a new grant waits for the next cycle.
          if (rsp_accept) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: stands in for the shared ALU and checks grants,
// latency, response stability and reset against a transaction-level model.
module tb_alu_arbiter;

  logic        clock = 1'b0;
  logic        resetn;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_z;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_z;
  logic [31:0] req0_a, req0_b, rsp0_s, req1_a, req1_b, rsp1_s;
  logic [3:0]  req0_aluc, req1_aluc, alu_aluc;
  logic [31:0] alu_a, alu_b, alu_s;
  logic        alu_z;

  int n_checks = 0;
  int n_errors = 0;
  int mlast;

  always #5 clock = ~clock;

  alu_arbiter #(.DATA_W(32), .RST_PRIO(0)) dut (
    .clock(clock), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_aluc(req0_aluc), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_s(rsp0_s), .rsp0_z(rsp0_z),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_aluc(req1_aluc), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_s(rsp1_s), .rsp1_z(rsp1_z),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_s(alu_s), .alu_z(alu_z)
  );

  // Single-pass ALU behaviour; HAMM counts differing bits of the low 4-bit lane only.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] c);
    casez (c)
      4'b?000: return a + b;
      4'b?100: return a - b;
      4'b?001: return a & b;
      4'b?101: return a | b;
      4'b?010: return a ^ b;
      4'b?110: return {b[15:0], 16'h0000};
      4'b0011: return b << a[4:0];
      4'b0111: return b >> a[4:0];
      4'b1111: return 32'($signed(b) >>> a[4:0]);
      4'b1011: return 32'($countones((a ^ b) & 32'h0000_000F));
      default: return 32'h0;
    endcase
  endfunction

  always_comb begin
    alu_s = alu_fn(alu_a, alu_b, alu_aluc);
    alu_z = (alu_s == 32'h0);
  end

  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] c);
`ifdef ALU_ARB_HAMM32_EN
    if (c == 4'b1011) return 32'($countones(a ^ b));
`endif
    return alu_fn(a, b, c);
  endfunction

  function automatic int exp_latency(input logic [3:0] c);
`ifdef ALU_ARB_HAMM32_EN
    if (c == 4'b1011) return 9;
`endif
    return 2;
  endfunction

  function automatic int model_pick(input logic v0, input logic v1, input int last);
    if (v0 && v1) return (last == 0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    resetn     = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_aluc = '0;
    req1_a = '0; req1_b = '0; req1_aluc = '0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    mlast  = 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rsp_valid"}, {30'b0, rsp1_valid, rsp0_valid}, 32'h0);
    check_eq({tag, "_rsp0_s"}, rsp0_s, 32'h0);
    check_eq({tag, "_rsp1_s"}, rsp1_s, 32'h0);
    check_eq({tag, "_rsp_z"}, {30'b0, rsp1_z, rsp0_z}, 32'h0);
    check_eq({tag, "_alu_a"}, alu_a, 32'h0);
    check_eq({tag, "_alu_b"}, alu_b, 32'h0);
    check_eq({tag, "_alu_aluc"}, 32'(alu_aluc), 32'h0);
  endtask

  // Called just after a negedge with requests driven; ends just after the accepting edge.
  task automatic serve(input int hold, output int w, output logic [31:0] got_s);
    logic [31:0] es;
    int          lat;
    bit          seen;
    logic        vld;
    #1;
    w = model_pick(req0_valid, req1_valid, mlast);
    got_s = '0;
    check_eq("grant0", 32'(req0_ready), 32'(w == 0));
    check_eq("grant1", 32'(req1_ready), 32'(w == 1));
    if (w < 0) return;
    if (w == 0) begin
      es = ref_result(req0_a, req0_b, req0_aluc); lat = exp_latency(req0_aluc);
    end else begin
      es = ref_result(req1_a, req1_b, req1_aluc); lat = exp_latency(req1_aluc);
    end
    @(posedge clock); #1;
    mlast = w;
    // Winner's port is free to change; the non-owner's rsp_ready must be ignored.
    if (w == 0) begin
      req0_valid = 1'b0; req0_a = $urandom; req0_b = $urandom; req0_aluc = 4'($urandom);
      rsp1_ready = 1'b1;
    end else begin
      req1_valid = 1'b0; req1_a = $urandom; req1_b = $urandom; req1_aluc = 4'($urandom);
      rsp0_ready = 1'b1;
    end
    seen = 1'b0;
    for (int cyc = 1; cyc <= 12 && !seen; cyc++) begin
      @(negedge clock);
      vld = (w == 0) ? rsp0_valid : rsp1_valid;
      check_eq("other_rsp_valid", 32'((w == 0) ? rsp1_valid : rsp0_valid), 32'h0);
      check_eq("busy_ready", {30'b0, req1_ready, req0_ready}, 32'h0);
      if (vld) begin
        seen = 1'b1;
        check_eq("latency", 32'(cyc), 32'(lat));
      end
    end
    if (!seen) check_eq("rsp_timeout", 32'h0, 32'h1);
    got_s = (w == 0) ? rsp0_s : rsp1_s;
    check_eq("rsp_s", got_s, es);
    check_eq("rsp_z", 32'((w == 0) ? rsp0_z : rsp1_z), 32'(es == 32'h0));
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check_eq("hold_valid", 32'((w == 0) ? rsp0_valid : rsp1_valid), 32'h1);
      check_eq("hold_s", (w == 0) ? rsp0_s : rsp1_s, es);
      check_eq("hold_z", 32'((w == 0) ? rsp0_z : rsp1_z), 32'(es == 32'h0));
      check_eq("hold_ready", {30'b0, req1_ready, req0_ready}, 32'h0);
    end
    if (w == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    #1;
    check_eq("accept_ready", {30'b0, req1_ready, req0_ready}, 32'h0);
    @(posedge clock); #1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    check_eq("rsp_clear", {30'b0, rsp1_valid, rsp0_valid}, 32'h0);
  endtask

  task automatic reset_midflight(input bit in_resp);
    int bad = 0;
    @(negedge clock);
    req0_valid = 1'b1; req0_a = 32'h0000_1234; req0_b = 32'h0000_0011; req0_aluc = 4'b0000;
    @(posedge clock); #1;
    req0_valid = 1'b0;
    @(negedge clock);
    if (in_resp) begin
      @(negedge clock);
      check_eq("pre_reset_valid", 32'(rsp0_valid), 32'h1);
    end
    resetn = 1'b0;
    #1;
    check_reset_outputs(in_resp ? "rst_resp" : "rst_exec");
    check_eq("rst_ready", {30'b0, req1_ready, req0_ready}, 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    mlast  = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (rsp0_valid || rsp1_valid) bad++;
    end
    check_eq("no_rsp_after_reset", 32'(bad), 32'h0);
  endtask

  initial begin
    int          w;
    logic [31:0] s;
    bit          pend0, pend1;
    logic [3:0]  ops [10];
    ops = '{4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010, 4'b0110,
            4'b0011, 4'b0111, 4'b1111, 4'b1011};

    do_reset();
    #1;
    check_reset_outputs("reset");
    check_eq("reset_ready", {30'b0, req1_ready, req0_ready}, 32'h0);

    // ADD 5+3 from req0.
    @(negedge clock);
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_aluc = 4'b0000;
    serve(0, w, s);
    check_eq("add_winner", 32'(w), 32'h0);
    check_eq("add_s", s, 32'd8);

    // req1 SUB 7-7 wins the tie (req0 went last); req0 (SRA) waits through a long hold.
    @(negedge clock);
    req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd7; req1_aluc = 4'b0100;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'hF000_0000; req0_aluc = 4'b1111;
    serve(10, w, s);
    check_eq("sub_winner", 32'(w), 32'h1);
    check_eq("sub_s", s, 32'h0);
    @(negedge clock);
    serve(0, w, s);
    check_eq("sra_winner", 32'(w), 32'h0);
    check_eq("sra_s", s, 32'hF800_0000);

    // HAMM of all-ones against zero.
    @(negedge clock);
    req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'h0; req0_aluc = 4'b1011;
    serve(1, w, s);
`ifdef ALU_ARB_HAMM32_EN
    check_eq("hamm_s", s, 32'd32);
`else
    check_eq("hamm_s", s, 32'd4);
`endif

    // Tie right after reset goes to req0, then strict alternation.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_aluc = 4'b0010;
      if (!req1_valid) begin
        req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom; req1_aluc = 4'b0101;
      end
      if (i > 0 && i % 2 == 1) req0_valid = 1'b1;
      serve(0, w, s);
      check_eq("alternate_order", 32'(w), 32'(i % 2));
      if (w == 1) begin
        req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom; req1_aluc = 4'b0101;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    reset_midflight(1'b0);
    reset_midflight(1'b1);
    @(negedge clock);
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 32'd9; req0_b = 32'd4; req0_aluc = 4'b0100;
    req1_a = 32'd2; req1_b = 32'd2; req1_aluc = 4'b0000;
    serve(0, w, s);
    check_eq("post_reset_prio", 32'(w), 32'h0);
    req1_valid = 1'b0;

    // Randomized traffic.
    pend0 = 1'b0; pend1 = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clock);
      if (!pend0 && ($urandom_range(1) == 1)) begin
        pend0 = 1'b1; req0_a = $urandom; req0_b = $urandom;
        req0_aluc = ops[$urandom_range(9)];
      end
      if (!pend1 && ($urandom_range(1) == 1)) begin
        pend1 = 1'b1; req1_a = $urandom; req1_b = $urandom;
        req1_aluc = ops[$urandom_range(9)];
      end
      if (!pend0 && !pend1) begin
        pend1 = 1'b1; req1_a = $urandom; req1_b = $urandom;
        req1_aluc = ops[$urandom_range(9)];
      end
      req0_valid = pend0; req1_valid = pend1;
      serve($urandom_range(3), w, s);
      if (w == 0) pend0 = 1'b0;
      else if (w == 1) pend1 = 1'b0;
      else break;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
